// File: rtl/register_16bit_unload_pkg.sv
// rtl/register_16bit_unload_pkg.sv - shared widths and state type for the 16-bit byte unloader
package register_16bit_unload_pkg;

    localparam int WORDW = 16;
    localparam int BYTEW = 8;

    // Which byte of the held word is currently on the byte port
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SENDFIRST  = 2'd1,
        SENDSECOND = 2'd2
    } unload_state_t;

endpackage : register_16bit_unload_pkg

// File: rtl/register_16bit_unload.sv
// rtl/register_16bit_unload.sv - unloads a 16-bit word as two tagged bytes over valid/ready
module register_16bit_unload
    import register_16bit_unload_pkg::*;
#(
    parameter bit HIGHFIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WORDW-1:0] wordin,
    input  logic             wordvalid,
    output logic             wordready,
    output logic [BYTEW-1:0] byteout,
    output logic             bytevalid,
    input  logic             byteready,
    output logic             storehigh,
    output logic             storelow,
    output logic             busy
);

    unload_state_t    state_q, state_d;
    logic [WORDW-1:0] held_q, held_d;

    logic word_hs;
    logic byte_hs;
    logic high_sel;

    // Handshakes, ready and the byte mux; the byte side only looks at registered state
    always_comb begin
        wordready = reset && ((state_q == IDLE) ||
                              ((state_q == SENDSECOND) && byteready));
        bytevalid = (state_q != IDLE);
        busy      = (state_q != IDLE);
        word_hs   = wordvalid && wordready;
        byte_hs   = bytevalid && byteready;

        // The first byte is the high half exactly when HIGHFIRST is set
        high_sel  = bytevalid && ((state_q == SENDFIRST) == HIGHFIRST);
        storehigh = high_sel;
        storelow  = bytevalid && !high_sel;

        if (!bytevalid) begin
            byteout = '0;
        end else if (high_sel) begin
            byteout = held_q[WORDW-1:BYTEW];
        end else begin
            byteout = held_q[BYTEW-1:0];
        end
    end

    // Next-state: a new word is captured only on its handshake, so a changing wordin is ignored while busy
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        case (state_q)
            IDLE: begin
                if (word_hs) begin
                    held_d  = wordin;
                    state_d = SENDFIRST;
                end
            end
            SENDFIRST: begin
                if (byte_hs) begin
                    state_d = SENDSECOND;
                end
            end
            SENDSECOND: begin
                if (byte_hs) begin
                    if (word_hs) begin
                        held_d  = wordin;
                        state_d = SENDFIRST;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and holding registers; reset discards any partially sent word
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

endmodule : register_16bit_unload
